// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner:
// segment table, blank pattern and display mode encoding.
package sevenseg_pkg;

  // Segments {g,f,e,d,c,b,a}, entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    MODE_HEX = 2'd0,
    MODE_LZB = 2'd1,
    MODE_OFF = 2'd2
  } mode_e;

endpackage

// File: rtl/sevenseg_scan_key.sv
// Pushbutton conditioning: 2-flop synchroniser, counter debouncer
// and a single-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_prev;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_prev  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], key_in};
      r_prev <= r_level;
      // Any sample matching the accepted level restarts the run.
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_level & ~r_prev;

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed hex display driver with frame snapshots and a
// debounced mode key cycling HEX / leading-zero blank / OFF.
import sevenseg_pkg::*;

module sevenseg_scan #(
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key,
  input  logic [4*NUM_DIGITS-1:0] enc,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  output logic [6:0]              seg_d,
  output logic                    dot,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SW-1:0]           r_scan;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_enc;
  logic [NUM_DIGITS-1:0]   r_dp;
  mode_e                   r_mode;
  mode_e                   w_mode_nxt;

  logic                    w_press;
  logic                    w_frame;
  logic [4*NUM_DIGITS-1:0] w_enc;
  logic [NUM_DIGITS-1:0]   w_dp;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_allz;
  logic                    w_run;
  logic                    w_blank;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk   (clk),
    .rst   (rst),
    .key_in(key),
    .press (w_press)
  );

  // The frame-start edge decodes the values being captured.
  assign w_frame = (r_scan == '0) && (r_idx == '0);
  assign w_enc   = w_frame ? enc   : r_enc;
  assign w_dp    = w_frame ? dp_en : r_dp;
  assign w_nib   = w_enc[4*r_idx +: 4];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_enc  <= '0;
      r_dp   <= '0;
    end else begin
      if (w_frame) begin
        r_enc <= enc;
        r_dp  <= dp_en;
      end
      if (r_scan == SW'(SCAN_DIV - 1)) begin
        r_scan <= '0;
        r_idx  <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_mode <= MODE_HEX;
    else      r_mode <= w_mode_nxt;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_press) begin
      case (r_mode)
        MODE_HEX: w_mode_nxt = MODE_LZB;
        MODE_LZB: w_mode_nxt = MODE_OFF;
        default:  w_mode_nxt = MODE_HEX;
      endcase
    end
  end

  // w_allz[i]: nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    w_allz = '0;
    w_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run     = w_run & (w_enc[4*i +: 4] == 4'h0);
      w_allz[i] = w_run;
    end
  end

  assign w_blank = (r_mode == MODE_LZB) && (r_idx != '0) && w_allz[r_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_d   <= SEG_BLANK;
      dot     <= 1'b0;
      dig_sel <= '0;
    end else begin
      dig_sel <= NUM_DIGITS'(1) << r_idx;
      if (r_mode == MODE_OFF) begin
        seg_d <= SEG_BLANK;
        dot   <= 1'b0;
      end else begin
        seg_d <= w_blank ? SEG_BLANK : SEG_TABLE[w_nib];
        dot   <= w_dp[r_idx];
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: frame-aligned expected words
// {dig_sel, seg_d, dot} are queued per frame and popped each cycle.
module tb_sevenseg_scan;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int DC = 8;
  localparam int FR = ND * SD;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        key   = 1'b0;
  logic [15:0] enc   = 16'h00A5;
  logic [3:0]  dp_en = 4'b0100;
  logic [6:0]  seg_d;
  logic        dot;
  logic [3:0]  dig_sel;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] sb[$];
  logic [11:0] exp_w;

  sevenseg_scan #(
    .NUM_DIGITS     (ND),
    .SCAN_DIV       (SD),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .enc    (enc),
    .dp_en  (dp_en),
    .seg_d  (seg_d),
    .dot    (dot),
    .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;
      4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;
      4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;
      4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;
      4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // m: 0 = HEX, 1 = LZB, 2 = OFF
  function automatic logic [11:0] model(input logic [15:0] e,
                                        input logic [3:0] dp,
                                        input int m, input int d);
    logic [15:0] hi;
    logic [6:0]  s;
    logic        o;
    logic [3:0]  sel;
    hi  = e >> (4 * d);
    s   = seg_of(hi[3:0]);
    o   = dp[d];
    sel = 4'b0001 << d;
    if (m == 1 && d > 0 && hi == 16'h0) s = 7'h00;
    if (m == 2) begin
      s = 7'h00;
      o = 1'b0;
    end
    return {sel, s, o};
  endfunction

  task automatic push_frame(input logic [15:0] e, input logic [3:0] dp,
                            input int m);
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < SD; c++)
        sb.push_back(model(e, dp, m, d));
  endtask

  task automatic press_key();
    key = 1'b1;
    repeat (FR) @(negedge clk);
    key = 1'b0;
    repeat (FR) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (seg_d !== 7'h00) begin
      n_fail++;
      $display("FAIL reset_seg got %h exp 00", seg_d);
    end
    n_tests++;
    if (dot !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dot got %b exp 0", dot);
    end
    n_tests++;
    if (dig_sel !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_sel got %b exp 0000", dig_sel);
    end
    rst = 1'b1;
  endtask

  task automatic test_hex();
    push_frame(16'h00A5, dp_en, 0);
    for (int p = 0; p < FR; p++) begin
      @(negedge clk);
      exp_w = sb.pop_front();
      n_tests++;
      if ({dig_sel, seg_d, dot} !== exp_w) begin
        n_fail++;
        $display("FAIL hex p%0d got %h exp %h", p,
                 {dig_sel, seg_d, dot}, exp_w);
      end
    end
  endtask

  task automatic test_snapshot();
    enc = 16'h1234;
    push_frame(16'h1234, dp_en, 0);
    for (int p = 0; p < FR; p++) begin
      @(negedge clk);
      exp_w = sb.pop_front();
      n_tests++;
      if ({dig_sel, seg_d, dot} !== exp_w) begin
        n_fail++;
        $display("FAIL snap_old p%0d got %h exp %h", p,
                 {dig_sel, seg_d, dot}, exp_w);
      end
      if (p == 6) enc = 16'h5678;
    end
    push_frame(16'h5678, dp_en, 0);
    for (int p = 0; p < FR; p++) begin
      @(negedge clk);
      exp_w = sb.pop_front();
      n_tests++;
      if ({dig_sel, seg_d, dot} !== exp_w) begin
        n_fail++;
        $display("FAIL snap_new p%0d got %h exp %h", p,
                 {dig_sel, seg_d, dot}, exp_w);
      end
    end
  endtask

  task automatic test_lzb();
    enc = 16'h00A5;
    press_key();
    push_frame(16'h00A5, dp_en, 1);
    push_frame(16'h0000, dp_en, 1);
    for (int p = 0; p < 2 * FR; p++) begin
      @(negedge clk);
      exp_w = sb.pop_front();
      n_tests++;
      if ({dig_sel, seg_d, dot} !== exp_w) begin
        n_fail++;
        $display("FAIL lzb p%0d got %h exp %h", p,
                 {dig_sel, seg_d, dot}, exp_w);
      end
      if (p == FR - 1) enc = 16'h0000;
    end
  endtask

  task automatic test_off();
    enc = 16'h1234;
    press_key();
    push_frame(16'h1234, dp_en, 2);
    for (int p = 0; p < FR; p++) begin
      @(negedge clk);
      exp_w = sb.pop_front();
      n_tests++;
      if ({dig_sel, seg_d, dot} !== exp_w) begin
        n_fail++;
        $display("FAIL off p%0d got %h exp %h", p,
                 {dig_sel, seg_d, dot}, exp_w);
      end
    end
  endtask

  task automatic test_bounce();
    // Bouncing must not be accepted: the display stays OFF meanwhile.
    push_frame(16'h1234, dp_en, 2);
    push_frame(16'h1234, dp_en, 2);
    for (int i = 0; i < 3 * FR; i++) begin
      key = ((i / 3) % 2) == 0;
      @(negedge clk);
      if (i >= FR) begin
        exp_w = sb.pop_front();
        n_tests++;
        if ({dig_sel, seg_d, dot} !== exp_w) begin
          n_fail++;
          $display("FAIL bounce i%0d got %h exp %h", i,
                   {dig_sel, seg_d, dot}, exp_w);
        end
      end
    end
    key = 1'b1;
    repeat (2 * FR) @(negedge clk);
    key = 1'b0;
    repeat (FR) @(negedge clk);
    push_frame(16'h1234, dp_en, 0);
    for (int p = 0; p < FR; p++) begin
      @(negedge clk);
      exp_w = sb.pop_front();
      n_tests++;
      if ({dig_sel, seg_d, dot} !== exp_w) begin
        n_fail++;
        $display("FAIL bounce_hex p%0d got %h exp %h", p,
                 {dig_sel, seg_d, dot}, exp_w);
      end
    end
  endtask

  task automatic test_held();
    key = 1'b1;
    repeat (4 * FR) @(negedge clk);
    key = 1'b0;
    repeat (FR) @(negedge clk);
    push_frame(16'h1234, dp_en, 1);
    for (int p = 0; p < FR; p++) begin
      @(negedge clk);
      exp_w = sb.pop_front();
      n_tests++;
      if ({dig_sel, seg_d, dot} !== exp_w) begin
        n_fail++;
        $display("FAIL held p%0d got %h exp %h", p,
                 {dig_sel, seg_d, dot}, exp_w);
      end
    end
  endtask

  task automatic test_reset_mid();
    press_key();
    repeat (9) @(negedge clk);
    n_tests++;
    if (dig_sel !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_digit got %b exp 0100", dig_sel);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({dig_sel, seg_d, dot} !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_reset got %h exp 000", {dig_sel, seg_d, dot});
    end
    rst = 1'b1;
    push_frame(16'h1234, dp_en, 0);
    for (int p = 0; p < FR; p++) begin
      @(negedge clk);
      exp_w = sb.pop_front();
      n_tests++;
      if ({dig_sel, seg_d, dot} !== exp_w) begin
        n_fail++;
        $display("FAIL restart p%0d got %h exp %h", p,
                 {dig_sel, seg_d, dot}, exp_w);
      end
    end
  endtask

  task automatic test_partial();
    key = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    key = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_frame(16'h1234, dp_en, 0);
    push_frame(16'h1234, dp_en, 0);
    for (int p = 0; p < 2 * FR; p++) begin
      @(negedge clk);
      exp_w = sb.pop_front();
      n_tests++;
      if ({dig_sel, seg_d, dot} !== exp_w) begin
        n_fail++;
        $display("FAIL partial p%0d got %h exp %h", p,
                 {dig_sel, seg_d, dot}, exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_snapshot();
    test_lzb();
    test_off();
    test_bounce();
    test_held();
    test_reset_mid();
    test_partial();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
